// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: holds the bus for init, then grants refresh > write > read
// one at a time and muxes the granted requester onto the pins, with a grant watchdog.
module sdram_arbit #(
  parameter int unsigned TIMEOUT = 1023,
  parameter logic [3:0]  CMD_NOP = 4'b0111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_ba,
  input  logic [11:0] init_addr,
  input  logic        aref_req,
  input  logic        aref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [11:0] aref_addr,
  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_ba,
  input  logic [11:0] wr_addr,
  input  logic        wr_dq_oe,
  input  logic [15:0] wr_data,
  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_ba,
  input  logic [11:0] rd_addr,
  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_bank,
  output logic [11:0] sdram_addr,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe,
  output logic        arb_err
);

  localparam int unsigned CW = 10;
  localparam int unsigned BW = 2;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;

  typedef enum logic [2:0] {S_INIT, S_ARBIT, S_AREF, S_WRITE, S_READ} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_gnt_cnt;
  logic          r_arb_err;
  logic          w_granted;
  logic          w_end;
  logic          w_timeout;
  logic [3:0]    w_cmd;

  // Grant bookkeeping: which end pulse releases the current owner, and the watchdog trip
  always_comb begin
    w_granted = (r_state == S_AREF) || (r_state == S_WRITE) || (r_state == S_READ);
    w_end     = ((r_state == S_AREF)  && aref_end) ||
                ((r_state == S_WRITE) && wr_end)   ||
                ((r_state == S_READ)  && rd_end);
    w_timeout = w_granted && !w_end && (r_gnt_cnt == CW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_INIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:  if (init_end) w_state_nxt = S_ARBIT;
      S_ARBIT: begin
        if (aref_req)    w_state_nxt = S_AREF;
        else if (wr_req) w_state_nxt = S_WRITE;
        else if (rd_req) w_state_nxt = S_READ;
      end
      S_AREF, S_WRITE, S_READ: if (w_end || w_timeout) w_state_nxt = S_ARBIT;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // Grant counter restarts from zero on every new grant and saturates rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt_cnt <= '0;
      r_arb_err <= 1'b0;
    end else begin
      r_arb_err <= w_timeout;
      if (!w_granted)              r_gnt_cnt <= '0;
      else if (r_gnt_cnt != '1)    r_gnt_cnt <= r_gnt_cnt + CW'(1);
    end
  end

  // Pin mux and grant decode; init pass-through is suppressed while reset is held
  always_comb begin
    aref_en      = 1'b0;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    sdram_cke    = 1'b1;
    w_cmd        = CMD_NOP;
    sdram_bank   = '0;
    sdram_addr   = '0;
    sdram_dq_out = '0;
    sdram_dq_oe  = 1'b0;
    case (r_state)
      S_INIT: if (rst_n) begin
        w_cmd      = init_cmd;
        sdram_bank = BW'(init_ba);
        sdram_addr = AW'(init_addr);
      end
      S_AREF: begin
        aref_en    = 1'b1;
        w_cmd      = aref_cmd;
        sdram_addr = AW'(aref_addr);
      end
      S_WRITE: begin
        wr_en        = 1'b1;
        w_cmd        = wr_cmd;
        sdram_bank   = BW'(wr_ba);
        sdram_addr   = AW'(wr_addr);
        sdram_dq_out = DW'(wr_data);
        sdram_dq_oe  = wr_dq_oe;
      end
      S_READ: begin
        rd_en      = 1'b1;
        w_cmd      = rd_cmd;
        sdram_bank = BW'(rd_ba);
        sdram_addr = AW'(rd_addr);
      end
      default: ;
    endcase
    {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = w_cmd;
  end

  assign arb_err = r_arb_err;

endmodule

// File: tb/tb_sdram_arbit.sv
// Self-checking bench for sdram_arbit: directed scenarios plus random traffic compared
// every cycle against an ownership-based model of the arbiter.
module tb_sdram_arbit;

  localparam int unsigned TIMEOUT = 1023;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_end = 1'b0;
  logic [3:0]  init_cmd = 4'b0111;
  logic [1:0]  init_ba = 2'b00;
  logic [11:0] init_addr = 12'h000;
  logic        aref_req = 1'b0, aref_end = 1'b0;
  logic [3:0]  aref_cmd = 4'b0001;
  logic [11:0] aref_addr = 12'h000;
  logic        wr_req = 1'b0, wr_end = 1'b0, wr_dq_oe = 1'b0;
  logic [3:0]  wr_cmd = 4'b0100;
  logic [1:0]  wr_ba = 2'b00;
  logic [11:0] wr_addr = 12'h000;
  logic [15:0] wr_data = 16'h0000;
  logic        rd_req = 1'b0, rd_end = 1'b0;
  logic [3:0]  rd_cmd = 4'b0101;
  logic [1:0]  rd_ba = 2'b00;
  logic [11:0] rd_addr = 12'h000;
  logic        aref_en, wr_en, rd_en, sdram_cke;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_bank;
  logic [11:0] sdram_addr;
  logic [15:0] sdram_dq_out;
  logic        sdram_dq_oe, arb_err;

  sdram_arbit #(.TIMEOUT(TIMEOUT), .CMD_NOP(4'b0111)) dut (
    .clk(clk), .rst_n(rst_n), .init_end(init_end),
    .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
    .wr_dq_oe(wr_dq_oe), .wr_data(wr_data),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
    .sdram_we_n(sdram_we_n), .sdram_bank(sdram_bank), .sdram_addr(sdram_addr),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe), .arb_err(arb_err)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus (0 none, 1 refresh, 2 write, 3 read) and for how many cycles
  bit m_init_done = 1'b0;
  int m_owner = 0;
  int m_held = 0;
  bit m_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_init_done = 1'b0;
      m_owner     = 0;
      m_held      = 0;
      m_err       = 1'b0;
    end else begin
      m_err = 1'b0;
      if (!m_init_done) begin
        if (init_end) m_init_done = 1'b1;
      end else if (m_owner == 0) begin
        m_owner = aref_req ? 1 : wr_req ? 2 : rd_req ? 3 : 0;
        m_held  = 0;
      end else if ((m_owner == 1 && aref_end) || (m_owner == 2 && wr_end) ||
                   (m_owner == 3 && rd_end)) begin
        m_owner = 0;
      end else begin
        m_held++;
        if (m_held == TIMEOUT) begin
          m_owner = 0;
          m_err   = 1'b1;
        end
      end
    end
  end

  function automatic logic [39:0] exp_vec();
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [11:0] ad;
    logic [15:0] dq;
    logic        oe;
    cmd = 4'b0111; ba = 2'b00; ad = 12'h000; dq = 16'h0000; oe = 1'b0;
    if (rst_n && !m_init_done) begin
      cmd = init_cmd; ba = init_ba; ad = init_addr;
    end else if (m_owner == 1) begin
      cmd = aref_cmd; ad = aref_addr;
    end else if (m_owner == 2) begin
      cmd = wr_cmd; ba = wr_ba; ad = wr_addr; dq = wr_data; oe = wr_dq_oe;
    end else if (m_owner == 3) begin
      cmd = rd_cmd; ba = rd_ba; ad = rd_addr;
    end
    return {m_owner == 1, m_owner == 2, m_owner == 3, 1'b1, cmd, ba, ad, dq, oe, m_err};
  endfunction

  wire [39:0] w_act = {aref_en, wr_en, rd_en, sdram_cke, sdram_cs_n, sdram_ras_n,
                       sdram_cas_n, sdram_we_n, sdram_bank, sdram_addr, sdram_dq_out,
                       sdram_dq_oe, arb_err};
  wire [3:0]  w_cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
  wire [2:0]  w_ens = {aref_en, wr_en, rd_en};

  always @(negedge clk) chk("cycle", w_act, exp_vec());

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  int n_wr, n_err, err_at, rd_at;

  initial begin
    init_cmd  = 4'b0010;
    init_addr = 12'h400;
    wr_req    = 1'b1;
    repeat (5) cyc();
    chk("rst_pins", {sdram_cke, w_cmd, sdram_bank, sdram_addr}, {1'b1, 4'b0111, 2'b00, 12'h000});
    chk("rst_no_grant", w_ens, 3'b000);
    rst_n = 1'b1;
    cyc();
    chk("init_pins", {w_cmd, sdram_addr}, {4'b0010, 12'h400});
    chk("init_no_grant", w_ens, 3'b000);
    cyc();

    init_end = 1'b1; aref_req = 1'b1; rd_req = 1'b1;
    cyc();
    chk("handoff_nop", {w_ens, w_cmd}, {3'b000, 4'b0111});
    cyc();
    chk("aref_first", w_ens, 3'b100);
    repeat (2) cyc();
    aref_end = 1'b1; aref_req = 1'b0;
    cyc();
    chk("gap_after_aref", {w_ens, w_cmd}, {3'b000, 4'b0111});
    aref_end = 1'b0;
    cyc();
    chk("wr_second", w_ens, 3'b010);
    wr_dq_oe = 1'b1; wr_data = 16'hA5A5;
    cyc();
    chk("dq_oe_on", {sdram_dq_oe, sdram_dq_out}, {1'b1, 16'hA5A5});
    wr_dq_oe = 1'b0;
    cyc();
    chk("dq_oe_off", sdram_dq_oe, 1'b0);
    wr_end = 1'b1; wr_req = 1'b0;
    cyc();
    chk("gap_after_wr", w_ens, 3'b000);
    wr_end = 1'b0;
    cyc();
    chk("rd_third", w_ens, 3'b001);
    wr_dq_oe = 1'b1;
    cyc();
    chk("rd_no_oe", {sdram_dq_oe, sdram_dq_out}, {1'b0, 16'h0000});
    rd_end = 1'b1; rd_req = 1'b0; wr_dq_oe = 1'b0;
    cyc();
    rd_end = 1'b0;

    // Reset in the middle of a write grant
    wr_req = 1'b1;
    cyc();
    cyc();
    chk("mid_wr_granted", wr_en, 1'b1);
    rst_n = 1'b0; init_end = 1'b0;
    #1;
    chk("async_drop", {w_ens, w_cmd, sdram_dq_oe}, {3'b000, 4'b0111, 1'b0});
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (3) begin
      cyc();
      chk("no_grant_before_init", wr_en, 1'b0);
    end
    init_end = 1'b1;
    cyc();
    cyc();
    chk("wr_after_reinit", w_ens, 3'b010);

    // Watchdog: hold the write grant with no end pulse
    wr_req = 1'b0; rd_req = 1'b1;
    n_wr = 1; n_err = 0; err_at = -1; rd_at = -1;
    for (int i = 1; i < 1200 && rd_at < 0; i++) begin
      cyc();
      if (wr_en) n_wr++;
      if (arb_err) begin
        n_err++;
        err_at = i;
        chk("err_in_arbit", w_ens, 3'b000);
      end
      if (rd_en) rd_at = i;
    end
    chk("timeout_len", n_wr, TIMEOUT);
    chk("err_pulses", n_err, 1);
    chk("rd_after_err", rd_at, err_at + 1);
    rd_end = 1'b1; rd_req = 1'b0;
    cyc();
    rd_end = 1'b0;

    // Random traffic, including end pulses that do not match the current grant
    repeat (2000) begin
      aref_req  = ($urandom_range(0, 5) == 0);
      wr_req    = ($urandom_range(0, 2) == 0);
      rd_req    = ($urandom_range(0, 2) == 0);
      aref_end  = ($urandom_range(0, 3) == 0);
      wr_end    = ($urandom_range(0, 3) == 0);
      rd_end    = ($urandom_range(0, 3) == 0);
      wr_dq_oe  = 1'($urandom);
      wr_data   = 16'($urandom);
      init_cmd  = 4'($urandom);
      init_ba   = 2'($urandom);
      init_addr = 12'($urandom);
      aref_cmd  = 4'($urandom);
      aref_addr = 12'($urandom);
      wr_cmd    = 4'($urandom);
      wr_ba     = 2'($urandom);
      wr_addr   = 12'($urandom);
      rd_cmd    = 4'($urandom);
      rd_ba     = 2'($urandom);
      rd_addr   = 12'($urandom);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_arbit.md
# sdram_arbit

Command-bus arbiter for the 16-bit SDRAM controller (12-bit address, 2-bit bank, 9-bit column). It sits inside `sdram_top`, between the init, auto-refresh, write and read sub-controllers, and the SDRAM pins. It holds the bus for init until initialization completes. After that it grants the bus to one requester at a time, with priority refresh > write > read. It muxes the granted requester's command, bank, address and write data onto the pins.

## Interface
- `TIMEOUT`, 1023: maximum cycles a grant may be held without the matching `*_end`.
- `CMD_NOP`, 4'b0111: {cs_n, ras_n, cas_n, we_n} idle command.
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: asynchronous active-low reset.
- `init_end` in 1: init sequence done; level, stays high.
- `init_cmd`, `init_ba`, `init_addr` in 4/2/12: init command, bank and address.
- `aref_req` in 1: refresh request; level, held until granted.
- `aref_end` in 1: refresh done; one-cycle pulse.
- `aref_cmd`, `aref_addr` in 4/12: refresh command and address.
- `wr_req`, `rd_req` in 1: write/read request; level.
- `wr_end`, `rd_end` in 1: write/read done; one-cycle pulse.
- `wr_cmd`, `wr_ba`, `wr_addr` in 4/2/12: write command, bank and address.
- `rd_cmd`, `rd_ba`, `rd_addr` in 4/2/12: read command, bank and address.
- `wr_dq_oe` in 1: write module drives data this cycle.
- `wr_data` in 16: write data.
- `aref_en`, `wr_en`, `rd_en` out 1: grant to the requester.
- `sdram_cke` out 1: clock enable.
- `sdram_cs_n`, `sdram_ras_n`, `sdram_cas_n`, `sdram_we_n` out 1: command pins.
- `sdram_bank` out 2: bank pins.
- `sdram_addr` out 12: address pins.
- `sdram_dq_out` out 16: write data; `sdram_top` builds the tristate.
- `sdram_dq_oe` out 1: output enable for `sdram_dq`.
- `arb_err` out 1: one-cycle pulse on grant timeout.

## Operation
- FSM states: INIT, ARBIT, AREF, WRITE, READ. Reset state is INIT.
- INIT:
  - Pins carry `init_cmd`, `init_ba`, `init_addr`.
  - Goes to ARBIT on the first cycle `init_end`=1.
  - All `*_req` are ignored in INIT.
- ARBIT:
  - Pins carry `CMD_NOP`, bank 2'b00, addr 12'h000.
  - Selects the next state from the request levels: `aref_req` → AREF, else `wr_req` → WRITE, else `rd_req` → READ, else stay in ARBIT.
- AREF, WRITE, READ:
  - The matching `*_en`=1.
  - Pins carry the matching module's cmd, ba and addr; refresh bank is 2'b00.
  - On the matching `*_end`=1 the FSM returns to ARBIT.
- No preemption. The write and read modules sample `aref_req` themselves and end their burst early, terminating with precharge. The arbiter only waits for `*_end`.
- A `*_end` that does not match the current state is ignored.
- Data path:
  - `sdram_dq_oe` = (state==WRITE) & `wr_dq_oe`.
  - `sdram_dq_out` = `wr_data` in WRITE, else 16'h0000.
- `sdram_cke` is 1 in every state after reset.
- Timeout:
  - A 10-bit grant counter clears on entering AREF, WRITE or READ and increments each cycle in those states.
  - When the count reaches `TIMEOUT` without `*_end`, the FSM forces ARBIT and pulses `arb_err` for one cycle.
  - The counter saturates and does not wrap.
- Reset mid-operation: state → INIT, pins → NOP, all enables 0, dq_oe 0. Init must then rerun, with `init_end` deasserted by the init module's own reset.

## Timing
- Reset values:
  - state INIT; aref_en, wr_en, rd_en all 0; arb_err 0.
  - sdram_cke 1; cs_n/ras_n/cas_n/we_n = 0111.
  - bank 0, addr 0, dq_out 0, dq_oe 0.
- The state register is clocked on the rising edge of `clk`. The pin mux and `*_en` decode are combinational from state, so a sub-module's command reaches the pins in the same cycle it is presented.
- Grant latency: a request sampled in ARBIT at edge N gives `*_en`=1 in cycle N+1.
- Release: `*_end` at edge N puts the FSM in ARBIT (NOP) for cycle N+1. Every grant is separated by at least one ARBIT NOP cycle.
- Simultaneous requests in ARBIT resolve by fixed priority in the same cycle. The losing requests stay pending with their levels held.
- `init_end` and `aref_req` arriving in the same cycle while in INIT: the FSM goes INIT→ARBIT first, then grants AREF one cycle later.
- Timeout: `arb_err` is high in the cycle the FSM is in ARBIT following the forced exit.

## Test plan
- Reset: drop `rst_n` to 0 for 100 ns, with `init_end` held at 0 throughout → pins 0111, cke 1, state INIT, and no grants even with `wr_req`=1.
- Init handoff: `init_cmd`=4'b0010 (precharge) with addr 12'h400 → pins show 0010/400. Raise `init_end` → the next cycle shows NOP.
- Priority: from ARBIT, assert `aref_req`, `wr_req` and `rd_req` together → `aref_en` next cycle. After `aref_end` → 1 ARBIT cycle, then `wr_en`. After `wr_end` → 1 ARBIT cycle, then `rd_en`.
- Write data path: in WRITE with `wr_dq_oe`=1 and `wr_data`=16'hA5A5 → `sdram_dq_oe`=1 and `sdram_dq_out`=A5A5. With `wr_dq_oe`=0 → oe 0. In READ, oe stays 0 regardless.
- Reset mid-write: drop `rst_n` while `wr_en`=1 → `wr_en` goes 0 asynchronously, pins NOP, state INIT. Subsequent `wr_req` is not granted until `init_end` is seen again.
- Timeout: hold WRITE with no `wr_end` for 1023 cycles → `arb_err` pulses once, FSM is in ARBIT, `wr_en` drops, and a pending `rd_req` is granted 1 cycle later.
